// File: rtl/inst_rom_loader_pkg.sv
// rtl/inst_rom_loader_pkg.sv - shared types and constants for the instruction ROM loader
package inst_rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } ld_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/inst_rom_loader_if.sv
// rtl/inst_rom_loader_if.sv - fetch and byte-stream loader signals between host/core and the ROM
interface inst_rom_loader_if #(
  parameter int AW = 32
) ();

  logic [AW-1:0] inst_addr_rom;
  logic [31:0]   inst_rom;
  logic          core_rstn;
  logic          ld_start;
  logic [31:0]   ld_len;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic [31:0]   ld_sum;

  modport master (
    output inst_addr_rom, ld_start, ld_len, ld_valid, ld_data,
    input  inst_rom, core_rstn, ld_ready, ld_done, ld_sum
  );

  modport slave (
    input  inst_addr_rom, ld_start, ld_len, ld_valid, ld_data,
    output inst_rom, core_rstn, ld_ready, ld_done, ld_sum
  );

endinterface

// File: rtl/inst_rom_loader_byte_packer.sv
// rtl/inst_rom_loader_byte_packer.sv - packs four little-endian bytes into a 32-bit word
module inst_rom_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // The fourth byte bypasses the register so the word is written on its own edge.
  assign word       = {byte_data, shift_q};
  assign word_valid = byte_valid && (cnt_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    shift_q[7:0]   <= byte_data;
        2'd1:    shift_q[15:8]  <= byte_data;
        2'd2:    shift_q[23:16] <= byte_data;
        default: shift_q        <= '0;
      endcase
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction memory with fetch port, byte-stream loader and core reset hold
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int          DEPTH    = 4096,
  parameter int          AW       = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  bus
);

  localparam int             AI      = $clog2(DEPTH);
  localparam int             PW      = AI + 1;
  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);

  ld_state_t     state, next_state;
  logic [PW-1:0] len_q, ptr_q, len_new;
  logic [31:0]   sum_q;
  logic          core_rstn_q;
  logic [31:0]   mem [DEPTH];

  logic          ld_ready_c, ld_done_c;
  logic [31:0]   inst_rom_c;
  logic          start_ok, byte_fire, word_valid;
  logic [31:0]   word;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus.inst_addr_rom[1:0];

  assign start_ok  = bus.ld_start && ((state == ST_IDLE) || (state == ST_RUN));
  assign len_new   = (bus.ld_len > 32'(DEPTH)) ? DEPTH_P : bus.ld_len[PW-1:0];
  assign byte_fire = bus.ld_valid && ld_ready_c;

  inst_rom_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (byte_fire),
    .byte_data  (bus.ld_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_RUN: if (bus.ld_start) next_state = (len_new == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:         if (word_valid && (ptr_q + PW'(1) == len_q)) next_state = ST_DONE;
      ST_DONE:         next_state = ST_RUN;
      default:         next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready_c = (state == ST_LOAD);
    ld_done_c  = (state == ST_DONE);
    inst_rom_c = NOP_WORD;
    if ((state == ST_RUN) && (bus.inst_addr_rom[AW-1:AI+2] == '0))
      inst_rom_c = mem[bus.inst_addr_rom[AI+1:2]];
  end

  assign bus.ld_ready  = ld_ready_c;
  assign bus.ld_done   = ld_done_c;
  assign bus.inst_rom  = inst_rom_c;
  assign bus.core_rstn = core_rstn_q;
  assign bus.ld_sum    = sum_q;

  // core_rstn follows next_state so it is a clean flop output aligned with entering/leaving RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      ptr_q       <= '0;
      sum_q       <= '0;
      core_rstn_q <= 1'b0;
    end else begin
      core_rstn_q <= (next_state == ST_RUN);
      if (start_ok) begin
        len_q <= len_new;
        ptr_q <= '0;
        sum_q <= '0;
      end else if (word_valid) begin
        ptr_q <= ptr_q + PW'(1);
        sum_q <= sum_q + word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_valid) mem[ptr_q[AI-1:0]] <= word;
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - directed self-checking bench for inst_rom_loader
module tb_inst_rom_loader;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  inst_rom_loader_if #(.AW(32)) bus ();

  inst_rom_loader #(
    .DEPTH    (4096),
    .AW       (32),
    .NOP_WORD (32'h0000_0013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] len);
    bus.ld_start = 1'b1;
    bus.ld_len   = len;
    step();
    bus.ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int t;
    t = 0;
    if (throttle) begin
      bus.ld_valid = 1'b0;
      step();
    end
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    while (!bus.ld_ready && t < 50) begin
      step();
      t++;
    end
    if (!bus.ld_ready) chk("byte_ready_timeout", 32'(bus.ld_ready), 32'd1);
    step();
    bus.ld_valid = 1'b0;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.inst_addr_rom = addr;
    #1;
    chk(tag, bus.inst_rom, exp);
  endtask

  task automatic send_prog(input bit throttle);
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    for (int i = 0; i < 8; i++) send_byte(prog[i], throttle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst               = 1'b1;
    bus.inst_addr_rom = '0;
    bus.ld_start      = 1'b0;
    bus.ld_len        = '0;
    bus.ld_valid      = 1'b0;
    bus.ld_data       = '0;
    step();
    step();

    // Reset state
    chk("rst_core_rstn", 32'(bus.core_rstn), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
    chk("rst_ld_sum", bus.ld_sum, 32'h0);
    fetch_chk("rst_fetch0", 32'h0, 32'h0000_0013);
    fetch_chk("rst_fetch100", 32'h100, 32'h0000_0013);
    rst = 1'b0;
    step();
    chk("idle_core_rstn", 32'(bus.core_rstn), 32'd0);

    // Two-word load, full-rate stream
    start_load(32'd2);
    chk("load_ready", 32'(bus.ld_ready), 32'd1);
    send_prog(1'b0);
    chk("load_done_pulse", 32'(bus.ld_done), 32'd1);
    chk("load_sum", bus.ld_sum, 32'h00F0_0AA6);
    chk("done_core_rstn", 32'(bus.core_rstn), 32'd0);
    step();
    chk("run_done_low", 32'(bus.ld_done), 32'd0);
    chk("run_core_rstn", 32'(bus.core_rstn), 32'd1);
    chk("run_ready_low", 32'(bus.ld_ready), 32'd0);
    fetch_chk("run_fetch4", 32'h4, 32'h0050_0593);
    fetch_chk("run_fetch0", 32'h0, 32'h00A0_0513);
    fetch_chk("run_fetch6", 32'h6, 32'h0050_0593);
    fetch_chk("run_fetch_oob", 32'h0000_4000, 32'h0000_0013);

    // Reload from RUN with a throttled stream
    start_load(32'd2);
    chk("reload_core_rstn", 32'(bus.core_rstn), 32'd0);
    chk("reload_sum_clr", bus.ld_sum, 32'h0);
    fetch_chk("reload_fetch_nop", 32'h4, 32'h0000_0013);
    send_prog(1'b1);
    chk("thr_done_pulse", 32'(bus.ld_done), 32'd1);
    chk("thr_sum", bus.ld_sum, 32'h00F0_0AA6);
    step();
    fetch_chk("thr_fetch0", 32'h0, 32'h00A0_0513);
    fetch_chk("thr_fetch4", 32'h4, 32'h0050_0593);

    // Zero-length load goes straight to DONE and never accepts bytes
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hFF;
    start_load(32'd0);
    chk("zero_done_pulse", 32'(bus.ld_done), 32'd1);
    chk("zero_ready_low", 32'(bus.ld_ready), 32'd0);
    step();
    chk("zero_run_core_rstn", 32'(bus.core_rstn), 32'd1);
    chk("zero_done_low", 32'(bus.ld_done), 32'd0);
    chk("zero_sum", bus.ld_sum, 32'h0);
    bus.ld_valid = 1'b0;
    fetch_chk("zero_fetch0", 32'h0, 32'h00A0_0513);

    // Reset in the middle of a load
    start_load(32'd2);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    chk("mid_sum", bus.ld_sum, 32'h4433_2211);
    rst = 1'b1;
    #2;
    chk("mid_rst_core_rstn", 32'(bus.core_rstn), 32'd0);
    chk("mid_rst_sum", bus.ld_sum, 32'h0);
    chk("mid_rst_ready", 32'(bus.ld_ready), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Fresh one-word load, with a stray ld_start mid-load that must be ignored
    start_load(32'd1);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    bus.ld_start = 1'b1;
    bus.ld_len   = 32'd0;
    step();
    bus.ld_start = 1'b0;
    chk("ignore_start_ready", 32'(bus.ld_ready), 32'd1);
    chk("ignore_start_done", 32'(bus.ld_done), 32'd0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    chk("fresh_done_pulse", 32'(bus.ld_done), 32'd1);
    chk("fresh_sum", bus.ld_sum, 32'hDEAD_BEEF);
    step();
    chk("fresh_core_rstn", 32'(bus.core_rstn), 32'd1);
    fetch_chk("fresh_fetch0", 32'h0, 32'hDEAD_BEEF);
    fetch_chk("fresh_fetch4_kept", 32'h4, 32'h0050_0593);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
